lstm_seq_ctrl: RTL and testbench
================================

// Module: lstm_seq_ctrl
// PURPOSE
//  Timestep sequencer that drives the LSTM array's control interface (sel, load, load_h).
//  Replaces hand-timed bench stimulus: one start pulse runs NUM_ITERATIONS timesteps of
//  calculate -> load -> load_h.
//  Also supplies the current timestep index and the MAC index, used to address the input
//  memory, plus busy/done status for the training top level.
// PARAMETERS
//  NUM            45  array inputs per timestep (x + bias); sets CALC phase length
//  NUM_ITERATIONS 8   timesteps per sequence
//  CALC_CYCLES    43  cycles in CALC phase per timestep (>=1)
//  T_W            4   width of timestep index (2**T_W >= NUM_ITERATIONS)
//  C_W            8   width of phase counter (2**C_W > CALC_CYCLES)
// PORTS
//  clk      in   1    single clock, rising edge
//  rst      in   1    reset: asynchronous, active-low
//  start    in   1    1-cycle request to run a sequence; sampled only in IDLE
//  busy     out  1    high from cycle after accepted start until DONE state exits
//  done     out  1    1-cycle pulse, sequence complete
//  sel      out  1    0 = array uses zero h_prev (t0), 1 = fed-back h
//  load     out  1    1-cycle pulse, array latches gate results
//  load_h   out  1    1-cycle pulse, array computes/latches h
//  t_idx    out  T_W  current timestep 0..NUM_ITERATIONS-1
//  mac_idx  out  C_W  cycle within CALC phase 0..CALC_CYCLES-1; 0 outside CALC
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-low.
//  Reset values, all outputs 0: busy, done, sel, load, load_h, t_idx, mac_idx.
//  Reset state: IDLE.
//  Reset asserted mid-sequence: immediate return to IDLE with all outputs 0.
//  No partial pulse survives reset.
//  FSM states and transitions (all registered, outputs decoded from registered state/counters):
//   IDLE : start=1 -> CALC; t_idx<=0, cnt<=0, sel<=0. Else stay.
//   CALC : cnt increments each cycle.
//          At cnt==CALC_CYCLES-1 -> LOAD.
//          mac_idx = cnt.
//   LOAD : load=1 for exactly this cycle -> LOADH.
//   LOADH: load_h=1 for exactly this cycle.
//          If t_idx==NUM_ITERATIONS-1 -> DONE.
//          Else -> CALC with t_idx+1, cnt<=0, sel<=1.
//   DONE : done=1 for exactly this cycle -> IDLE.
//          busy deasserts on entry to IDLE; t_idx holds last value until next start.
//  Timestep length: CALC_CYCLES+2 cycles.
//  Sequence length: start to done pulse = NUM_ITERATIONS*(CALC_CYCLES+2)+1 cycles.
//   Defaults: 361 cycles.
//  sel is 0 throughout timestep 0, including its load/load_h.
//  sel is 1 from the first CALC cycle of timestep 1 to DONE.
//  sel clears to 0 on the next accepted start.
//  load and load_h are never high together.
//  load_h is always the cycle immediately after load.
//  start while busy (CALC/LOAD/LOADH/DONE) is ignored; no queuing.
//  start in the same cycle as the done pulse is ignored; start is honoured only in IDLE.
//  NUM_ITERATIONS==1: single timestep, sel stays 0, done follows the first load_h.
//  Counters never wrap: cnt saturates by state change.
//  t_idx never exceeds NUM_ITERATIONS-1.
// TESTING
//  T1 reset: rst=0 mid-CALC at t_idx=3 -> all outputs 0 immediately (async).
//     T1 release: after release, outputs stay idle until start.
//  T2 nominal (defaults): start at cycle 0 -> busy=1 from cycle 1; first load at cycle 44.
//     T2 nominal, continued: first load_h at cycle 45; load at cycles 44+45k, k=0..7.
//     T2 end of sequence: done at cycle 361; busy=0 from cycle 362.
//  T3 sel: sel=0 through cycle 45 (t0 load_h).
//     T3 sel, continued: sel=1 from cycle 46 to 361; sel=0 after the next start.
//  T4 index: mac_idx counts 0..42 in each CALC phase and is 0 in LOAD/LOADH.
//     T4 index, continued: t_idx steps 0->7, one step per 45 cycles.
//  T5 start ignored: start pulses at cycles 10, 200 and 361 -> no effect on timing.
//     T5, continued: count exactly 8 load, 8 load_h and 1 done.
//  T6 edge: NUM_ITERATIONS=1, CALC_CYCLES=1, start at cycle 0 -> load at cycle 2.
//     T6, continued: load_h at cycle 3, done at cycle 4, sel=0 throughout.

Source files
------------

// File: rtl/lstm_seq_ctrl.sv
// Timestep sequencer for the LSTM array: runs NUM_ITERATIONS rounds of
// calculate -> load -> load_h from a single start pulse.
module lstm_seq_ctrl #(
  parameter int NUM            = 45,
  parameter int NUM_ITERATIONS = 8,
  parameter int CALC_CYCLES    = 43,
  parameter int T_W            = 4,
  parameter int C_W            = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           sel,
  output logic           load,
  output logic           load_h,
  output logic [T_W-1:0] t_idx,
  output logic [C_W-1:0] mac_idx
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_LOADH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // MAC index never runs past the array's input count
  localparam int CALC_LEN =
    (CALC_CYCLES < NUM) ? CALC_CYCLES : NUM;

  localparam logic [C_W-1:0] CALC_END =
    C_W'(CALC_LEN - 1);
  localparam logic [T_W-1:0] T_END =
    T_W'(NUM_ITERATIONS - 1);

  logic [2:0]     state;
  logic [C_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      t_idx <= '0;
      sel   <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (start) begin
            state <= S_CALC;
            cnt   <= '0;
            t_idx <= '0;
            sel   <= 1'b0;
          end
        end
        (state == S_CALC): begin
          if (cnt == CALC_END) begin
            state <= S_LOAD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        (state == S_LOAD): begin
          state <= S_LOADH;
        end
        (state == S_LOADH): begin
          if (t_idx == T_END) begin
            state <= S_DONE;
          end else begin
            state <= S_CALC;
            cnt   <= '0;
            t_idx <= t_idx + 1'b1;
            sel   <= 1'b1;
          end
        end
        (state == S_DONE): begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign load    = (state == S_LOAD);
  assign load_h  = (state == S_LOADH);
  assign mac_idx = (state == S_CALC) ? cnt : '0;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl: default configuration plus a
// one-timestep, one-cycle-CALC instance, checked against a timing model.
module tb_lstm_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, start_a, rst_b, start_b;
  logic       busy_a, done_a, sel_a, load_a, lh_a;
  logic       busy_b, done_b, sel_b, load_b, lh_b;
  logic [3:0] t_a, t_b;
  logic [7:0] mac_a, mac_b;

  lstm_seq_ctrl u_a (
    .clk(clk), .rst(rst_a), .start(start_a),
    .busy(busy_a), .done(done_a), .sel(sel_a),
    .load(load_a), .load_h(lh_a),
    .t_idx(t_a), .mac_idx(mac_a)
  );

  lstm_seq_ctrl #(
    .NUM_ITERATIONS(1), .CALC_CYCLES(1)
  ) u_b (
    .clk(clk), .rst(rst_b), .start(start_b),
    .busy(busy_b), .done(done_b), .sel(sel_b),
    .load(load_b), .load_h(lh_b),
    .t_idx(t_b), .mac_idx(mac_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Expected outputs from elapsed cycles since the accepted start
  // {busy,done,sel,load,load_h,t_idx[3:0],mac_idx[7:0]}
  function automatic logic [16:0] model(
    int ni, int cc, int r, logic [3:0] lt, logic ls);
    int len, ts, ph;
    logic [16:0] o;
    o = '0;
    len = cc + 2;
    if (r < 0) begin
      o = {1'b0, 1'b0, ls, 1'b0, 1'b0, lt, 8'd0};
    end else if (r < ni * len) begin
      ts = r / len;
      ph = r % len;
      o[16]    = 1'b1;
      o[14]    = (ts > 0);
      o[13]    = (ph == cc);
      o[12]    = (ph == cc + 1);
      o[11:8]  = 4'(ts);
      o[7:0]   = (ph < cc) ? 8'(ph) : 8'd0;
    end else begin
      o[16]    = 1'b1;
      o[15]    = 1'b1;
      o[14]    = (ni > 1);
      o[11:8]  = 4'(ni - 1);
    end
    return o;
  endfunction

  int         r_a, r_b;
  logic [3:0] lt_a, lt_b;
  logic       ls_a, ls_b;

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      r_a <= -1; lt_a <= '0; ls_a <= 1'b0;
    end else if (r_a < 0) begin
      if (start_a) r_a <= 0;
    end else if (r_a == 8 * 45) begin
      r_a <= -1; lt_a <= 4'd7; ls_a <= 1'b1;
    end else begin
      r_a <= r_a + 1;
    end
  end

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_b <= -1; lt_b <= '0; ls_b <= 1'b0;
    end else if (r_b < 0) begin
      if (start_b) r_b <= 0;
    end else if (r_b == 3) begin
      r_b <= -1; lt_b <= 4'd0; ls_b <= 1'b0;
    end else begin
      r_b <= r_b + 1;
    end
  end

  wire [16:0] out_a =
    {busy_a, done_a, sel_a, load_a, lh_a, t_a, mac_a};
  wire [16:0] out_b =
    {busy_b, done_b, sel_b, load_b, lh_b, t_b, mac_b};

  always @(negedge clk) begin
    chk("cyc_a", int'(out_a), int'(model(8, 43, r_a, lt_a, ls_a)));
    chk("cyc_b", int'(out_b), int'(model(1, 1, r_b, lt_b, ls_b)));
  end

  int n_load, n_lh, n_done;

  // Start at cycle 0, then walk cycles 1..ncyc with optional stray starts
  task automatic run_a(int ncyc, bit stray);
    @(posedge clk); #1;
    start_a = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      start_a = stray && (k == 10 || k == 200 || k == 361);
      @(negedge clk);
      n_load += int'(load_a);
      n_lh   += int'(lh_a);
      n_done += int'(done_a);
      if (k == 1)   chk("t2_busy1", busy_a, 1);
      if (k == 1)   chk("t3_sel_restart", sel_a, 0);
      if (k == 43)  chk("t4_mac42", mac_a, 42);
      if (k == 44)  chk("t2_load44", load_a, 1);
      if (k == 44)  chk("t4_mac_load", mac_a, 0);
      if (k == 45)  chk("t2_lh45", lh_a, 1);
      if (k == 45)  chk("t3_sel45", sel_a, 0);
      if (k == 46)  chk("t3_sel46", sel_a, 1);
      if (k == 89)  chk("t2_load89", load_a, 1);
      if (k == 361) chk("t2_done361", done_a, 1);
      if (k == 361) chk("t4_tidx7", t_a, 7);
      if (k == 362) chk("t2_busy362", busy_a, 0);
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    n_load = 0; n_lh = 0; n_done = 0;
    repeat (3) @(negedge clk);
    chk("rst_a_zero", int'(out_a), 0);
    chk("rst_b_zero", int'(out_b), 0);
    #2;
    rst_a = 1'b1; rst_b = 1'b1;

    // T1: async reset inside timestep 3
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (145) @(posedge clk);
    #3;
    chk("t1_pre_tidx", t_a, 3);
    rst_a = 1'b0;
    #1;
    chk("t1_async_zero", int'(out_a), 0);
    @(negedge clk); #2;
    rst_a = 1'b1;
    repeat (10) @(negedge clk);
    chk("t1_idle_after", int'(out_a), 0);

    // T2-T5: nominal run with stray starts
    n_load = 0; n_lh = 0; n_done = 0;
    run_a(370, 1'b1);
    chk("t5_loads", n_load, 8);
    chk("t5_loadhs", n_lh, 8);
    chk("t5_dones", n_done, 1);
    chk("t3_sel_hold", sel_a, 1);

    // Second run: sel clears on the new start
    n_load = 0; n_lh = 0; n_done = 0;
    run_a(365, 1'b0);
    chk("rerun_loads", n_load, 8);

    // T6: one timestep, one CALC cycle
    @(posedge clk); #1;
    start_b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      start_b = 1'b0;
      @(negedge clk);
      chk("t6_sel", sel_b, 0);
      if (k == 2) chk("t6_load2", load_b, 1);
      if (k == 3) chk("t6_lh3", lh_b, 1);
      if (k == 4) chk("t6_done4", done_b, 1);
      if (k == 5) chk("t6_busy5", busy_b, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
